// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one MAC byte interface among NREQ frame sources.
// Enforces the inter-frame gap and the maximum frame length; define ETH_TX_ARB_PRIO_EN to make requester 0 strict priority.
module eth_tx_arbiter #(
  parameter int NREQ       = 2,
  parameter int IFG_CYCLES = 48,
  parameter int MAX_BYTES  = 1514
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*8-1:0] req_dat,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  output logic              mac_vld,
  output logic [7:0]        mac_dat,
  output logic              mac_last,
  input  logic              mac_rdy,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              ovf_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, IFG} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic            win_upd;
  logic [10:0]     bcnt;
  logic [IW-1:0]   ifg_cnt;
  logic            xfer;
  logic            at_max;
  logic            own_vld;
  logic            own_last;
  logic [7:0]      own_dat;

  assign own_vld  = req_vld[owner];
  assign own_last = req_last[owner];
  assign own_dat  = req_dat[int'(owner)*8 +: 8];
  assign at_max   = (bcnt == 11'(MAX_BYTES - 1));
  assign busy     = (state != IDLE);

  // Winner search starting just above the last owner, wrapping modulo NREQ
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_upd = 1'b0;
`ifdef ETH_TX_ARB_PRIO_EN
    if (req_vld[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
      win_upd = 1'b0;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        if (!win_vld && req_vld[(int'(rr_ptr) + i) % NREQ]) begin
          win_vld = 1'b1;
          win_idx = PW'((int'(rr_ptr) + i) % NREQ);
        end else begin
          win_vld = win_vld;
        end
      end
      win_upd = win_vld;
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_vld && req_vld[(int'(rr_ptr) + i) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end else begin
        win_vld = win_vld;
      end
    end
    win_upd = win_vld;
`endif
  end

  // Next-state decode and combinational owner pass-through
  always_comb begin
    state_nxt = state;
    mac_vld   = 1'b0;
    mac_dat   = 8'd0;
    mac_last  = 1'b0;
    req_rdy   = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = XFER;
        else         state_nxt = IDLE;
      end
      XFER: begin
        mac_vld        = own_vld;
        mac_dat        = own_dat;
        mac_last       = own_last | at_max;
        req_rdy[owner] = mac_rdy;
        xfer           = own_vld & mac_rdy;
        if (xfer && own_last)    state_nxt = IFG;
        else if (xfer && at_max) state_nxt = DRAIN;
        else                     state_nxt = XFER;
      end
      DRAIN: begin
        req_rdy[owner] = 1'b1;
        if (own_vld && own_last) state_nxt = IFG;
        else                     state_nxt = DRAIN;
      end
      IFG: begin
        if (ifg_cnt == IW'(0)) state_nxt = IDLE;
        else                   state_nxt = IFG;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and truncation pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ovf_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      ovf_err <= (state == XFER) && xfer && at_max && !own_last;
    end
  end

  // Grant, owner index and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= PW'(NREQ - 1);
    end else if (state == IDLE && win_vld) begin
      grant          <= '0;
      grant[win_idx] <= 1'b1;
      owner          <= win_idx;
      if (win_upd) rr_ptr <= win_idx;
    end else if (state_nxt == IFG) begin
      grant <= '0;
    end
  end

  // Per-frame byte counter, cleared while waiting in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= 11'd0;
    end else if (state == IDLE) begin
      bcnt <= 11'd0;
    end else if (xfer) begin
      bcnt <= bcnt + 11'd1;
    end
  end

  // Inter-frame gap down-counter, loaded on entry to IFG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifg_cnt <= IW'(0);
    end else if (state != IFG && state_nxt == IFG) begin
      ifg_cnt <= IW'(IFG_CYCLES - 1);
    end else if (state == IFG && ifg_cnt != IW'(0)) begin
      ifg_cnt <= ifg_cnt - IW'(1);
    end
  end

endmodule
